digit_entry_ctrl: RTL

Sequences the 8-digit seven-segment display path from keypad events. It consumes key codes and key-valid strobes from the matrix keypad scanner. It maintains an editable digit buffer with backspace, clear and enter commands, and drives the packed nibble bus and per-digit blank mask feeding the seg7 decoders. Buffer overflow raises a timed blinking error display.

---
 rtl/digit_entry_ctrl_pkg.sv | 21 ++
 rtl/digit_entry_ctrl_blink_timer.sv | 37 +++
 rtl/digit_entry_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/digit_entry_ctrl_pkg.sv
// Shared definitions for the keypad digit-entry controller: display size,
// command key codes and controller state encoding.
package digit_entry_ctrl_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [3:0] KEY_BKSP = 4'hA;
  localparam logic [3:0] KEY_CLR  = 4'hB;
  localparam logic [3:0] KEY_ENT  = 4'hC;

  typedef enum logic [1:0] {
    ST_ENTRY = 2'd0,
    ST_DONE  = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/digit_entry_ctrl_blink_timer.sv
// Free-running half-period divider for the error blink; tick marks the last
// cycle of each half-period, phase flips on that edge.
module digit_entry_ctrl_blink_timer #(
  parameter int DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic phase,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = en & (cnt_q == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      phase <= 1'b0;
    end else if (clr) begin
      cnt_q <= '0;
      phase <= 1'b0;
    end else if (en) begin
      if (tick) begin
        cnt_q <= '0;
        phase <= ~phase;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/digit_entry_ctrl.sv
// Keypad-driven digit buffer for the 8-digit seven-segment display path,
// with backspace/clear/enter commands and a timed blinking overflow error.
//
// state    | meaning
// ST_ENTRY | editing the buffer, digits shift in at digit0
// ST_DONE  | value committed, buffer held until next digit or clear
// ST_ERR   | overflow, display blinks until timeout or clear
module digit_entry_ctrl
  import digit_entry_ctrl_pkg::*;
#(
  parameter int BLINK_DIV   = 25_000_000,
  parameter int ERR_TOGGLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              key_code,
  input  logic                    key_valid,
  output logic [4*NUM_DIGITS-1:0] data8,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic [4*NUM_DIGITS-1:0] committed,
  output logic                    commit_pulse,
  output logic [3:0]              digit_count,
  output logic                    err
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int TW = $clog2(ERR_TOGGLES + 1);

  state_t        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] committed_q, committed_d;
  logic [3:0]    count_q, count_d;
  logic          pulse_q, pulse_d;
  logic [TW-1:0] tog_q, tog_d;
  logic          kv_q;
  logic          ev, in_err, phase, tick;
  logic [3:0]    eff_count;

  assign ev     = key_valid & ~kv_q;
  assign in_err = (state_q == ST_ERR);

  digit_entry_ctrl_blink_timer #(.DIV(BLINK_DIV)) u_blink_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (~in_err),
    .en    (in_err),
    .phase (phase),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ENTRY;
      data_q      <= '0;
      committed_q <= '0;
      count_q     <= '0;
      pulse_q     <= 1'b0;
      tog_q       <= '0;
      kv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      committed_q <= committed_d;
      count_q     <= count_d;
      pulse_q     <= pulse_d;
      tog_q       <= tog_d;
      kv_q        <= key_valid;
    end
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    committed_d = committed_q;
    count_d     = count_q;
    pulse_d     = 1'b0;
    tog_d       = in_err ? tog_q : '0;
    case (state_q)
      ST_ENTRY: begin
        if (ev) begin
          if (is_digit(key_code)) begin
            if (count_q == 4'(NUM_DIGITS)) begin
              state_d = ST_ERR;
            end else if (count_q != 4'd0 || key_code != 4'd0) begin
              // a leading zero on an empty buffer is swallowed
              data_d  = {data_q[DW-5:0], key_code};
              count_d = count_q + 4'd1;
            end
          end else if (key_code == KEY_BKSP) begin
            if (count_q != 4'd0) begin
              data_d  = data_q >> 4;
              count_d = count_q - 4'd1;
            end
          end else if (key_code == KEY_CLR) begin
            data_d  = '0;
            count_d = '0;
          end else if (key_code == KEY_ENT) begin
            committed_d = data_q;
            pulse_d     = 1'b1;
            state_d     = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (ev) begin
          if (is_digit(key_code)) begin
            data_d  = DW'(key_code);
            count_d = {3'b000, key_code != 4'd0};
            state_d = ST_ENTRY;
          end else if (key_code == KEY_CLR) begin
            data_d  = '0;
            count_d = '0;
            state_d = ST_ENTRY;
          end
        end
      end
      ST_ERR: begin
        if (ev && key_code == KEY_CLR) begin
          data_d  = '0;
          count_d = '0;
          state_d = ST_ENTRY;
        end else if (tick) begin
          if (tog_q == TW'(ERR_TOGGLES - 1)) begin
            tog_d   = '0;
            state_d = ST_ENTRY;
          end else begin
            tog_d = tog_q + TW'(1);
          end
        end
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  // digit0 stays lit even when empty so the display reads 0
  assign eff_count = (count_q == 4'd0) ? 4'd1 : count_q;

  always_comb begin
    blank = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      blank[i] = (i >= int'(eff_count));
    end
    if (in_err && phase) blank = '1;
  end

  assign data8        = data_q;
  assign committed    = committed_q;
  assign commit_pulse = pulse_q;
  assign digit_count  = count_q;
  assign err          = in_err;

endmodule
